// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin framebuffer write-port arbiter with burst lock, beat cap and stall timeout.
// Define FB_CLEAR_EN to zero-fill the framebuffer after reset before arbitration starts.
module fb_write_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 8,
  parameter int MAX_BURST     = 1280,
  parameter int STALL_TIMEOUT = 16,
  parameter int PIXEL_COUNT   = 307200
) (
  input  logic                      i_clk_sys,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ-1:0]        i_req_last,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_cpu_wr,
  output logic [ADDR_W-1:0]         o_cpu_addr,
  output logic [DATA_W-1:0]         o_cpu_data,
  output logic [1:0]                o_grant_id,
  output logic                      o_busy
);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [1:0] LAST_IDX = 2'(NUM_REQ - 1);
  typedef enum logic [1:0] {IDLE, GRANT, CLEAR} state_t;
  state_t r_state, w_state_nxt;
  logic [1:0] r_grant, w_grant_nxt, r_last_grant, w_last_grant_nxt, w_sel, w_cand;
  logic w_found, w_xfer, w_release, w_clr, w_clr_done;
  logic [BEAT_W-1:0] r_beat, w_beat_nxt;
  logic [STALL_W-1:0] r_stall, w_stall_nxt;
  logic [ADDR_W-1:0] w_addr, w_clr_addr, r_cpu_addr;
  logic [DATA_W-1:0] w_data, r_cpu_data;
  logic r_cpu_wr;
`ifdef FB_CLEAR_EN
  localparam state_t RST_STATE = CLEAR;
  logic [ADDR_W-1:0] r_clr_addr;
  always_ff @(posedge i_clk_sys or negedge i_rst_n)
    if (!i_rst_n) r_clr_addr <= '0;
    else if (w_clr) r_clr_addr <= r_clr_addr + ADDR_W'(1);
  assign w_clr = r_state == CLEAR;
  assign w_clr_done = w_clr && r_clr_addr == ADDR_W'(PIXEL_COUNT - 1);
  assign w_clr_addr = r_clr_addr;
`else
  localparam state_t RST_STATE = IDLE;
  assign w_clr = 1'b0;
  assign w_clr_done = 1'b0;
  assign w_clr_addr = '0;
`endif
  assign w_xfer = r_state == GRANT && i_req_valid[r_grant];
  assign w_addr = i_req_addr[int'(r_grant)*ADDR_W +: ADDR_W];
  assign w_data = i_req_data[int'(r_grant)*DATA_W +: DATA_W];
  // A burst ends on last, on the beat that fills the cap, or after a full stall window.
  assign w_release = w_xfer ? (i_req_last[r_grant] || r_beat == BEAT_W'(MAX_BURST - 1))
                            : (r_state == GRANT && r_stall == STALL_W'(STALL_TIMEOUT - 1));
  always_comb begin
    w_sel = r_last_grant;
    w_found = 1'b0;
    w_cand = (r_last_grant == LAST_IDX) ? 2'd0 : r_last_grant + 2'd1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req_valid[w_cand]) begin
        w_sel = w_cand;
        w_found = 1'b1;
      end
      w_cand = (w_cand == LAST_IDX) ? 2'd0 : w_cand + 2'd1;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_beat_nxt = r_beat;
    w_stall_nxt = r_stall;
    if (r_state == IDLE && w_found) begin
      w_state_nxt = GRANT;
      w_grant_nxt = w_sel;
      w_beat_nxt = '0;
      w_stall_nxt = '0;
    end
    if (r_state == GRANT) begin
      w_beat_nxt = w_xfer ? r_beat + BEAT_W'(1) : r_beat;
      w_stall_nxt = w_xfer ? '0 : r_stall + STALL_W'(1);
      w_state_nxt = w_release ? IDLE : GRANT;
      w_last_grant_nxt = w_release ? r_grant : r_last_grant;
    end
    if (w_clr_done) w_state_nxt = IDLE;
  end
  always_ff @(posedge i_clk_sys or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= RST_STATE;
      r_grant <= 2'd0;
      r_last_grant <= LAST_IDX;
      r_beat <= '0;
      r_stall <= '0;
      r_cpu_wr <= 1'b0;
      r_cpu_addr <= '0;
      r_cpu_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_beat <= w_beat_nxt;
      r_stall <= w_stall_nxt;
      r_cpu_wr <= w_xfer || w_clr;
      if (w_clr || w_xfer) begin
        r_cpu_addr <= w_clr ? w_clr_addr : w_addr;
        r_cpu_data <= w_clr ? '0 : w_data;
      end
    end
  always_comb begin
    o_req_ready = '0;
    if (r_state == GRANT) o_req_ready[r_grant] = 1'b1;
  end
  assign o_cpu_wr = r_cpu_wr;
  assign o_cpu_addr = r_cpu_addr;
  assign o_cpu_data = r_cpu_data;
  assign o_grant_id = r_grant;
  assign o_busy = r_state != IDLE;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: directed checks of fb_write_arbiter with MAX_BURST=4, STALL_TIMEOUT=16, PIXEL_COUNT=64.
module tb_fb_write_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] valid, last, ready;
  logic [95:0] addr;
  logic [23:0] data;
  logic wr, busy;
  logic [31:0] caddr;
  logic [7:0] cdata;
  logic [1:0] gid;
  int checks = 0, errors = 0;
  int rem[3];
  logic [31:0] nxt[3];
  logic [7:0] dval[3];
  logic uselast[3];
  logic [31:0] obs_addr[64];
  logic [7:0] obs_data[64];
  int nobs;
  logic [63:0] wr_hist;

  always #5 clk = ~clk;

  fb_write_arbiter #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(8), .MAX_BURST(4), .STALL_TIMEOUT(16), .PIXEL_COUNT(64)) dut (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_req_valid(valid), .i_req_last(last), .i_req_addr(addr),
    .i_req_data(data), .o_req_ready(ready), .o_cpu_wr(wr), .o_cpu_addr(caddr), .o_cpu_data(cdata),
    .o_grant_id(gid), .o_busy(busy));

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      valid[i] = rem[i] != 0;
      last[i] = uselast[i] && rem[i] == 1;
      addr[i*32 +: 32] = nxt[i];
      data[i*8 +: 8] = dval[i];
    end
  endtask

  task automatic setreq(input int i, input int n, input logic [31:0] a, input logic [7:0] d, input logic l);
    rem[i] = n;
    nxt[i] = a;
    dval[i] = d;
    uselast[i] = l;
  endtask

  task automatic clear_log();
    nobs = 0;
    wr_hist = '0;
    for (int i = 0; i < 64; i++) begin
      obs_addr[i] = 'x;
      obs_data[i] = 'x;
    end
  endtask

  task automatic step();
    logic [2:0] x;
    x = ready & valid;
    @(posedge clk);
    #1;
    wr_hist = {wr_hist[62:0], wr};
    if (wr && nobs < 64) begin
      obs_addr[nobs] = caddr;
      obs_data[nobs] = cdata;
      nobs++;
    end
    for (int i = 0; i < 3; i++)
      if (x[i]) begin
        rem[i]--;
        nxt[i]++;
      end
    drive();
  endtask

  task automatic apply_reset();
    for (int i = 0; i < 3; i++) setreq(i, 0, 0, 0, 1'b0);
    drive();
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
`ifdef FB_CLEAR_EN
    repeat (64) @(posedge clk);
    #1;
`endif
    clear_log();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) setreq(i, 0, 0, 0, 1'b0);
    drive();
    clear_log();
    rst_n = 1'b0;
    #3;
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %0h exp 0", wr); end
    checks++; if (caddr !== 32'd0) begin errors++; $display("FAIL reset_addr got %0h exp 0", caddr); end
    checks++; if (cdata !== 8'd0) begin errors++; $display("FAIL reset_data got %0h exp 0", cdata); end
    checks++; if (ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b exp 000", ready); end
    checks++; if (gid !== 2'd0) begin errors++; $display("FAIL reset_gid got %0d exp 0", gid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
`ifndef FB_CLEAR_EN
    step();
    checks++; if ({busy, wr} !== 2'b00) begin errors++; $display("FAIL reset_idle busy/wr got %b exp 00", {busy, wr}); end
`endif
  endtask

  task automatic test_single();
    apply_reset();
    setreq(1, 4, 32'd100, 8'hFF, 1'b1);
    drive();
    step();
    checks++; if (ready !== 3'b010) begin errors++; $display("FAIL single_ready got %b exp 010", ready); end
    checks++; if (gid !== 2'd1) begin errors++; $display("FAIL single_gid got %0d exp 1", gid); end
    repeat (4) step();
    checks++; if (wr_hist[4:0] !== 5'b01111) begin errors++; $display("FAIL single_wr_pattern got %b exp 01111", wr_hist[4:0]); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs_addr[i] !== 32'(100 + i)) begin errors++; $display("FAIL single_addr[%0d] got %0d exp %0d", i, obs_addr[i], 100 + i); end
      checks++; if (obs_data[i] !== 8'hFF) begin errors++; $display("FAIL single_data[%0d] got %0h exp ff", i, obs_data[i]); end
    end
    checks++; if ({busy, ready} !== 4'b0000) begin errors++; $display("FAIL single_idle busy/ready got %b exp 0000", {busy, ready}); end
    step();
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL single_wr_end got %0b exp 0", wr); end
  endtask

  task automatic test_round_robin();
    int e1[6] = '{200, 201, 300, 301, 400, 401};
    int e2[6] = '{210, 211, 310, 311, 410, 411};
    apply_reset();
    setreq(0, 2, 32'd200, 8'h10, 1'b1);
    setreq(1, 2, 32'd300, 8'h20, 1'b1);
    setreq(2, 2, 32'd400, 8'h30, 1'b1);
    drive();
    repeat (9) step();
    checks++; if (wr_hist[8:0] !== 9'b011011011) begin errors++; $display("FAIL rr1_wr_pattern got %b exp 011011011", wr_hist[8:0]); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (obs_addr[i] !== 32'(e1[i])) begin errors++; $display("FAIL rr1_addr[%0d] got %0d exp %0d", i, obs_addr[i], e1[i]); end
    end
    checks++; if (obs_data[2] !== 8'h20) begin errors++; $display("FAIL rr1_data got %0h exp 20", obs_data[2]); end
    clear_log();
    setreq(0, 2, 32'd210, 8'h10, 1'b1);
    setreq(1, 2, 32'd310, 8'h20, 1'b1);
    setreq(2, 2, 32'd410, 8'h30, 1'b1);
    drive();
    repeat (9) step();
    checks++; if (wr_hist[8:0] !== 9'b011011011) begin errors++; $display("FAIL rr2_wr_pattern got %b exp 011011011", wr_hist[8:0]); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (obs_addr[i] !== 32'(e2[i])) begin errors++; $display("FAIL rr2_addr[%0d] got %0d exp %0d", i, obs_addr[i], e2[i]); end
    end
  endtask

  task automatic test_beat_cap();
    int e[12] = '{500, 501, 502, 503, 700, 701, 504, 505, 506, 507, 508, 509};
    apply_reset();
    setreq(0, 10, 32'd500, 8'h11, 1'b0);
    setreq(2, 2, 32'd700, 8'h33, 1'b1);
    drive();
    repeat (16) step();
    checks++; if (wr_hist[15:0] !== 16'b0111101101111011) begin errors++; $display("FAIL cap_wr_pattern got %b exp 0111101101111011", wr_hist[15:0]); end
    checks++; if (nobs !== 12) begin errors++; $display("FAIL cap_beats got %0d exp 12", nobs); end
    for (int i = 0; i < 12; i++) begin
      checks++; if (obs_addr[i] !== 32'(e[i])) begin errors++; $display("FAIL cap_addr[%0d] got %0d exp %0d", i, obs_addr[i], e[i]); end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    setreq(1, 2, 32'd600, 8'h22, 1'b0);
    drive();
    step();
    setreq(0, 2, 32'd620, 8'h44, 1'b1);
    drive();
    repeat (2) step();
    checks++; if (nobs !== 2 || obs_addr[1] !== 32'd601) begin errors++; $display("FAIL stall_beats got %0d/%0d exp 2/601", nobs, obs_addr[1]); end
    repeat (15) step();
    checks++; if ({busy, gid, ready} !== 6'b101010) begin errors++; $display("FAIL stall_hold busy/gid/ready got %b exp 101010", {busy, gid, ready}); end
    step();
    checks++; if ({busy, ready} !== 4'b0000) begin errors++; $display("FAIL stall_release busy/ready got %b exp 0000", {busy, ready}); end
    step();
    checks++; if ({busy, gid, ready} !== 6'b100001) begin errors++; $display("FAIL stall_regrant busy/gid/ready got %b exp 100001", {busy, gid, ready}); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    apply_reset();
    setreq(0, 1, 32'd790, 8'h55, 1'b1);
    drive();
    repeat (2) step();
    setreq(0, 5, 32'd800, 8'h66, 1'b1);
    drive();
    while (!(wr === 1'b1 && caddr === 32'd802) && n < 20) begin
      step();
      n++;
    end
    checks++; if (n >= 20) begin errors++; $display("FAIL mid_reach_beat3 got timeout exp addr 802"); end
    checks++; if (ready !== 3'b001) begin errors++; $display("FAIL mid_ready_before got %b exp 001", ready); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({wr, ready, busy} !== 5'b00000) begin errors++; $display("FAIL mid_async wr/ready/busy got %b exp 00000", {wr, ready, busy}); end
    setreq(0, 5, 32'd800, 8'h66, 1'b1);
    setreq(1, 1, 32'd900, 8'h77, 1'b1);
    drive();
    #2;
    rst_n = 1'b1;
    clear_log();
    step();
`ifdef FB_CLEAR_EN
    repeat (64) step();
`endif
    checks++; if ({busy, gid, ready} !== 6'b100001) begin errors++; $display("FAIL mid_regrant busy/gid/ready got %b exp 100001", {busy, gid, ready}); end
  endtask

`ifdef FB_CLEAR_EN
  task automatic test_clear();
    for (int i = 0; i < 3; i++) setreq(i, 0, 0, 0, 1'b0);
    setreq(2, 1, 32'd990, 8'h99, 1'b1);
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    clear_log();
    for (int k = 0; k < 64; k++) begin
      step();
      checks++;
      if ({wr, caddr, cdata, ready, busy, gid} !== {1'b1, 32'(k), 8'h00, 3'b000, k != 63, 2'b00}) begin
        errors++;
        $display("FAIL clear_write[%0d] got wr=%0b addr=%0d data=%0h ready=%b busy=%0b gid=%0d", k, wr, caddr, cdata, ready, busy, gid);
      end
    end
    step();
    checks++; if ({busy, gid, ready, wr} !== 7'b1101000) begin errors++; $display("FAIL clear_grant busy/gid/ready/wr got %b exp 1101000", {busy, gid, ready, wr}); end
    step();
    checks++; if ({wr, caddr, cdata} !== {1'b1, 32'd990, 8'h99}) begin errors++; $display("FAIL clear_first_beat got %0b/%0d/%0h exp 1/990/99", wr, caddr, cdata); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_beat_cap();
    test_stall();
    test_reset_mid();
`ifdef FB_CLEAR_EN
    test_clear();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
